// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the fifo_async write port between
// NREQ requesters in the clk_a domain. The winner is granted a locked burst of
// req_len+1 beats. Each beat is pushed in any cycle where the FIFO is not full.
// There is one mandatory IDLE bubble between bursts.
// Optional build macro CMD_ARB_FIXED_PRIO_EN: when defined, the lowest-index
// requester always wins and the round-robin pointer stays at 0.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic                    clk_a,
  input  logic                    rst_a,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ack,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_wr_data
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]       r_state;
  logic [NREQ-1:0]  r_grant;
  logic [LEN_W-1:0] r_beat_cnt;
  logic [PTR_W-1:0] r_rr_ptr;

  logic             w_found;
  logic [PTR_W-1:0] w_win_idx;
  logic [NREQ-1:0]  w_win_onehot;
  logic [LEN_W-1:0] w_win_len;
  logic [WIDTH-1:0] w_grant_data;
  logic             w_push;

`ifdef CMD_ARB_FIXED_PRIO_EN
  // Winner search: the lowest-index active request wins. Scanning from high to
  // low lets the last match (the lowest index) overwrite earlier ones.
  always_comb begin
    w_found   = |req;
    w_win_idx = {PTR_W{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_win_idx = req[k] ? PTR_W'(k) : w_win_idx;
    end
  end
`else
  logic [PTR_W-1:0] r_owner;
  logic [PTR_W-1:0] w_next_ptr;

  // Winner search: circular scan starting at r_rr_ptr. Scanning offsets from
  // high to low leaves the nearest match at or after the pointer in w_win_idx.
  always_comb begin : p_rr_search
    int idx;
    w_found   = |req;
    w_win_idx = {PTR_W{1'b0}};
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx       = int'(r_rr_ptr) + k;
      idx       = (idx >= NREQ) ? (idx - NREQ) : idx;
      w_win_idx = req[idx] ? PTR_W'(idx) : w_win_idx;
    end
  end

  // Pointer advance: the slot after the finished owner, wrapping NREQ-1 -> 0.
  always_comb begin
    w_next_ptr = (r_owner == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}} : (r_owner + PTR_W'(1));
  end
`endif

  // One-hot form and burst length of the IDLE winner.
  always_comb begin
    w_win_onehot = {NREQ{1'b0}};
    w_win_len    = {LEN_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      w_win_onehot[i] = (PTR_W'(i) == w_win_idx);
      w_win_len       = (PTR_W'(i) == w_win_idx) ? req_len[i*LEN_W +: LEN_W] : w_win_len;
    end
  end

  // Data mux: select the beat data of the requester that owns the burst.
  always_comb begin
    w_grant_data = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      w_grant_data = r_grant[i] ? req_data[i*WIDTH +: WIDTH] : w_grant_data;
    end
  end

  // A beat is pushed in every BURST cycle in which the FIFO has room.
  assign w_push       = (r_state == ST_BURST) && !fifo_full;
  assign fifo_wr_en   = w_push;
  assign req_ack      = r_grant & {NREQ{w_push}};
  assign fifo_wr_data = w_push ? w_grant_data : {WIDTH{1'b0}};
  assign grant        = r_grant;
  assign busy         = (r_state == ST_BURST);

  // Arbitration FSM: grant in IDLE, count beats down in BURST, release on the last push.
  always_ff @(posedge clk_a) begin
    if (rst_a) begin
      r_state    <= ST_IDLE;
      r_grant    <= {NREQ{1'b0}};
      r_beat_cnt <= {LEN_W{1'b0}};
      r_rr_ptr   <= {PTR_W{1'b0}};
`ifndef CMD_ARB_FIXED_PRIO_EN
      r_owner    <= {PTR_W{1'b0}};
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state    <= ST_BURST;
            r_grant    <= w_win_onehot;
            r_beat_cnt <= w_win_len;
`ifndef CMD_ARB_FIXED_PRIO_EN
            r_owner    <= w_win_idx;
`endif
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (w_push) begin
            if (r_beat_cnt == {LEN_W{1'b0}}) begin
              r_state  <= ST_IDLE;
              r_grant  <= {NREQ{1'b0}};
`ifdef CMD_ARB_FIXED_PRIO_EN
              r_rr_ptr <= {PTR_W{1'b0}};
`else
              r_rr_ptr <= w_next_ptr;
`endif
            end else begin
              r_beat_cnt <= r_beat_cnt - LEN_W'(1);
            end
          end else begin
            // FIFO full: stall with grant and beat count held.
            r_beat_cnt <= r_beat_cnt;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= {NREQ{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, WIDTH=8, LEN_W=4).
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on the falling edge.
module tb_fifo_wr_arbiter;

  logic        clk_a;
  logic        rst_a;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic        busy;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CMD_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .LEN_W(4)) dut (
    .clk_a        (clk_a),
    .rst_a        (rst_a),
    .req          (req),
    .req_len      (req_len),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .grant        (grant),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data)
  );

  initial begin
    clk_a = 1'b0;
    forever #5 clk_a = ~clk_a;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_a);
  endtask

  task automatic check_idle(input string tag);
    check_value({tag, "_grant"}, {28'h0, grant}, 32'h0);
    check_value({tag, "_busy"},  {31'h0, busy}, 32'h0);
    check_value({tag, "_wren"},  {31'h0, fifo_wr_en}, 32'h0);
    check_value({tag, "_ack"},   {28'h0, req_ack}, 32'h0);
    check_value({tag, "_data"},  {24'h0, fifo_wr_data}, 32'h0);
  endtask

  task automatic check_push(input string tag, input logic [3:0] g, input logic [7:0] d);
    check_value({tag, "_grant"}, {28'h0, grant}, {28'h0, g});
    check_value({tag, "_busy"},  {31'h0, busy}, 32'h1);
    check_value({tag, "_wren"},  {31'h0, fifo_wr_en}, 32'h1);
    check_value({tag, "_ack"},   {28'h0, req_ack}, {28'h0, g});
    check_value({tag, "_data"},  {24'h0, fifo_wr_data}, {24'h0, d});
  endtask

  initial begin
    int pushes;
    int gidx;
    logic [3:0] eg;
    logic [7:0] ed;

    rst_a     = 1'b1;
    req       = 4'b0000;
    req_len   = 16'h0000;
    req_data  = 32'h0000_0000;
    fifo_full = 1'b0;

    // Reset state
    repeat (3) tick();
    settle();
    check_idle("rst");
    tick();
    rst_a = 1'b0;
    settle();
    check_idle("post_rst");

    // T1: single-beat burst from requester 0
    tick();
    req = 4'b0001; req_len[3:0] = 4'd0; req_data[7:0] = 8'hA5;
    settle();
    check_idle("t1_c0");
    tick();
    settle();
    check_push("t1_c1", 4'b0001, 8'hA5);
    tick();
    req = 4'b0000;
    settle();
    check_idle("t1_c2");

    // T2: requester 1, 4 beats, FIFO full in the 2nd and 3rd burst cycles
    tick();
    req = 4'b0010; req_len[7:4] = 4'd3; req_data[15:8] = 8'h3C;
    settle();
    check_idle("t2_c0");
    tick();
    pushes = 0;
    for (int i = 0; i < 6; i++) begin
      fifo_full = (i == 1) || (i == 2);
      settle();
      check_value("t2_grant", {28'h0, grant}, 32'h2);
      check_value("t2_wren", {31'h0, fifo_wr_en}, (i == 1 || i == 2) ? 32'h0 : 32'h1);
      check_value("t2_ack", {28'h0, req_ack}, (i == 1 || i == 2) ? 32'h0 : 32'h2);
      check_value("t2_data", {24'h0, fifo_wr_data}, (i == 1 || i == 2) ? 32'h0 : 32'h3C);
      if (fifo_wr_en) pushes++;
      tick();
    end
    req = 4'b0000; fifo_full = 1'b0;
    settle();
    check_value("t2_pushes", pushes, 32'd4);
    check_idle("t2_end");

    // T2b: pointer now at 2, req=0011 must search circularly and pick requester 0
    tick();
    req = 4'b0011; req_len[7:4] = 4'd0;
    settle();
    tick();
    settle();
    check_push("t2b", 4'b0001, 8'hA5);
    tick();
    req = 4'b0000;
    settle();
    check_idle("t2b_end");

    // Reset clears the pointer back to 0
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;

    // T3: all four request, length 0 each -> rotating grants every 2 cycles
    req = 4'b1111; req_len = 16'h0000; req_data = 32'h1312_1110;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 9) req = 4'b0000;
      settle();
      if (j % 2 == 0) begin
        gidx = FIXED ? 0 : ((j / 2) % 4);
        eg = 4'b0001 << gidx;
        ed = 8'h10 + 8'(gidx);
        check_push("t3_grant", eg, ed);
      end else begin
        check_idle("t3_gap");
      end
    end

    // T4: synchronous reset during the 3rd beat of an 8-beat burst
    tick();
    req = 4'b1000; req_len[15:12] = 4'd7; req_data[31:24] = 8'h77;
    settle();
    check_idle("t4_c0");
    tick();
    settle();
    check_push("t4_b1", 4'b1000, 8'h77);
    tick();
    settle();
    check_push("t4_b2", 4'b1000, 8'h77);
    tick();
    rst_a = 1'b1; req = 4'b0000;
    settle();
    check_push("t4_b3", 4'b1000, 8'h77);
    tick();
    rst_a = 1'b0;
    settle();
    check_idle("t4_rst");
    tick();
    req = 4'b0100; req_len[11:8] = 4'd0; req_data[23:16] = 8'h44;
    settle();
    check_idle("t4_r0");
    tick();
    settle();
    check_push("t4_r1", 4'b0100, 8'h44);
    tick();
    req = 4'b0000;
    settle();
    check_idle("t4_r2");

    // T5: maximum length, 16 beats, then IDLE with no re-entry
    tick();
    req = 4'b0001; req_len[3:0] = 4'hF; req_data[7:0] = 8'h5A;
    settle();
    pushes = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (pushes >= 16) req = 4'b0000;
      settle();
      if (!busy) break;
      if (fifo_wr_en) begin
        pushes++;
        check_value("t5_data", {24'h0, fifo_wr_data}, 32'h5A);
      end
    end
    check_value("t5_pushes", pushes, 32'd16);
    check_idle("t5_end");
    repeat (3) tick();
    settle();
    check_idle("t5_stay");

    // T6: req=0101 held; fixed priority always grants 0, round-robin alternates
    req = 4'b0101; req_len = 16'h0000; req_data = 32'h1312_1110;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (j == 7) req = 4'b0000;
      settle();
      if (j % 2 == 0) begin
        gidx = FIXED ? 0 : (((j / 2) % 2 == 0) ? 2 : 0);
        eg = 4'b0001 << gidx;
        ed = 8'h10 + 8'(gidx);
        check_push("t6_grant", eg, ed);
      end else begin
        check_idle("t6_gap");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
